// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM state
// encodings and the index of the hard-wired zero register.
package reg_dump_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Index 31 is XZR: it always reads as zero, whatever the port returns.
  localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Bundle of control, register-file read port A and dump stream signals.
// master: the dump reader; slave: register file plus dump consumer.
interface reg_dump_reader_if;
  logic        Start;
  logic        Abort;
  logic [4:0]  RA;
  logic [63:0] BusA;
  logic [63:0] DumpData;
  logic [4:0]  DumpIdx;
  logic        DumpValid;
  logic        DumpReady;
  logic        Busy;
  logic        Done;

  modport master (
    input  Start, Abort, BusA, DumpReady,
    output RA, DumpData, DumpIdx, DumpValid, Busy, Done
  );

  modport slave (
    output Start, Abort, BusA, DumpReady,
    input  RA, DumpData, DumpIdx, DumpValid, Busy, Done
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks register indices FIRST_REG..LAST_REG on read port A, holds each
// address READ_WAIT cycles, captures the data and streams it out with a
// valid/ready handshake. Abort drops the dump with no Done pulse.
//
// state | meaning
// IDLE  | waiting for Start
// WAIT  | RA driven, counting READ_WAIT cycles before capture
// SEND  | beat presented, waiting for DumpReady
// DONE  | one-cycle Done pulse after the last beat
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter logic [4:0] FIRST_REG = 5'd0,
  parameter logic [4:0] LAST_REG  = 5'd31,
  parameter int         READ_WAIT = 1
) (
  input logic              Clk,
  input logic              Reset,
  reg_dump_reader_if.master bus
);

  // Capture fires on the last counted cycle in WAIT.
  localparam logic [2:0] LP_WAIT_LAST = 3'(READ_WAIT - 1);

  state_t      r_state;
  logic [2:0]  r_wait_cnt;
  logic [4:0]  r_ra;
  logic [63:0] r_dump_data;
  logic [4:0]  r_dump_idx;
  logic        r_dump_valid;
  logic        r_busy;
  logic        r_done;

  // Sequencer: state, address, capture registers and status flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= 3'd0;
      r_ra         <= 5'd0;
      r_dump_data  <= 64'd0;
      r_dump_idx   <= 5'd0;
      r_dump_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.Start && !bus.Abort) begin
            r_ra       <= FIRST_REG;
            r_wait_cnt <= 3'd0;
            r_busy     <= 1'b1;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.Abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_wait_cnt == LP_WAIT_LAST) begin
            r_dump_data  <= (r_ra == XZR_IDX) ? 64'd0 : bus.BusA;
            r_dump_idx   <= r_ra;
            r_dump_valid <= 1'b1;
            r_wait_cnt   <= 3'd0;
            r_state      <= ST_SEND;
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end
        ST_SEND: begin
          // Abort wins; a beat accepted on the same edge is already gone.
          if (bus.Abort) begin
            r_dump_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (bus.DumpReady) begin
            r_dump_valid <= 1'b0;
            if (r_dump_idx == LAST_REG) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_ra       <= r_ra + 5'd1;
              r_wait_cnt <= 3'd0;
              r_state    <= ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_dump_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.RA        = r_ra;
  assign bus.DumpData  = r_dump_data;
  assign bus.DumpIdx   = r_dump_idx;
  assign bus.DumpValid = r_dump_valid;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: three instances cover the default
// range, a narrow range with back-pressure, and a longer read wait.
// Register file model: Xn reads as 64'h1000 + n.
module tb_reg_dump_reader;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   g;

  always #5 clk = ~clk;

  reg_dump_reader_if d0 ();
  reg_dump_reader_if d1 ();
  reg_dump_reader_if d2 ();

  assign d0.BusA = 64'h1000 + {59'd0, d0.RA};
  assign d1.BusA = 64'h1000 + {59'd0, d1.RA};
  assign d2.BusA = 64'h1000 + {59'd0, d2.RA};

  reg_dump_reader u_a (.Clk(clk), .Reset(rst_a), .bus(d0));
  reg_dump_reader #(.FIRST_REG(5'd3), .LAST_REG(5'd5)) u_b (.Clk(clk), .Reset(rst_b), .bus(d1));
  reg_dump_reader #(.READ_WAIT(3)) u_c (.Clk(clk), .Reset(rst_c), .bus(d2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    d0.Start = 0; d0.Abort = 0; d0.DumpReady = 0;
    d1.Start = 0; d1.Abort = 0; d1.DumpReady = 0;
    d2.Start = 0; d2.Abort = 0; d2.DumpReady = 0;
    #1;
    check("rst_valid", d0.DumpValid, 0);
    check("rst_busy",  d0.Busy, 0);
    check("rst_done",  d0.Done, 0);
    check("rst_ra",    d0.RA, 0);
    check("rst_idx",   d0.DumpIdx, 0);
    check("rst_data",  d0.DumpData, 0);
    tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();
    check("idle_busy", d0.Busy, 0);

    // Full default dump, Start pulses during the dump and in DONE ignored
    d0.DumpReady = 1;
    d0.Start = 1;
    tick();
    d0.Start = 0;
    check("a_start_busy", d0.Busy, 1);
    check("a_start_valid", d0.DumpValid, 0);
    check("a_start_ra", d0.RA, 0);
    tick();
    for (int i = 0; i < 32; i++) begin
      check("a_valid", d0.DumpValid, 1);
      check("a_idx", d0.DumpIdx, 64'(i));
      check("a_data", d0.DumpData, (i == 31) ? 64'h0 : 64'h1000 + 64'(i));
      check("a_ra", d0.RA, 64'(i));
      if (i == 10) d0.Start = 1;
      tick();
      d0.Start = 0;
      if (i < 31) begin
        check("a_drop", d0.DumpValid, 0);
        check("a_ra_inc", d0.RA, 64'(i + 1));
        check("a_nodone", d0.Done, 0);
        tick();
      end else begin
        check("a_last_drop", d0.DumpValid, 0);
        check("a_done", d0.Done, 1);
        check("a_done_busy", d0.Busy, 1);
        d0.Start = 1;
        tick();
        d0.Start = 0;
        check("a_done_clr", d0.Done, 0);
        check("a_idle_busy", d0.Busy, 0);
        tick();
        check("a_done_start_ign", d0.Busy, 0);
      end
    end

    // Start with Abort in IDLE
    d0.Start = 1; d0.Abort = 1;
    tick();
    d0.Start = 0; d0.Abort = 0;
    check("sa_busy", d0.Busy, 0);
    tick();
    check("sa_busy2", d0.Busy, 0);
    check("sa_valid", d0.DumpValid, 0);

    // Abort in SEND on idx 10
    d0.Start = 1;
    tick();
    d0.Start = 0;
    g = 0;
    while (!(d0.DumpValid === 1'b1 && d0.DumpIdx === 5'd10) && g < 200) begin
      tick();
      g++;
    end
    check("ab_reach10", (g < 200), 1);
    d0.DumpReady = 0;
    d0.Abort = 1;
    tick();
    d0.Abort = 0;
    check("ab_valid", d0.DumpValid, 0);
    check("ab_busy", d0.Busy, 0);
    check("ab_done", d0.Done, 0);
    check("ab_ra", d0.RA, 10);
    repeat (3) tick();
    check("ab_ra_hold", d0.RA, 10);
    check("ab_busy_hold", d0.Busy, 0);
    check("ab_done_hold", d0.Done, 0);
    d0.DumpReady = 1;

    // Asynchronous reset during WAIT on idx 7
    d0.Start = 1;
    tick();
    d0.Start = 0;
    g = 0;
    while (!(d0.RA === 5'd7 && d0.DumpValid === 1'b0 && d0.Busy === 1'b1) && g < 200) begin
      tick();
      g++;
    end
    check("rs_reach7", (g < 200), 1);
    #2 rst_a = 1'b1;
    #1;
    check("rs_ra", d0.RA, 0);
    check("rs_data", d0.DumpData, 0);
    check("rs_idx", d0.DumpIdx, 0);
    check("rs_valid", d0.DumpValid, 0);
    check("rs_busy", d0.Busy, 0);
    check("rs_done", d0.Done, 0);
    #2 rst_a = 1'b0;
    tick();
    tick();
    check("rs_wait_start", d0.Busy, 0);
    d0.Start = 1;
    tick();
    d0.Start = 0;
    tick();
    check("rs_restart_valid", d0.DumpValid, 1);
    check("rs_restart_idx", d0.DumpIdx, 0);
    check("rs_restart_data", d0.DumpData, 64'h1000);
    d0.Abort = 1;
    tick();
    d0.Abort = 0;
    check("rs_abort_busy", d0.Busy, 0);

    // Narrow range 3..5 with back-pressure on idx 4
    d1.DumpReady = 1;
    d1.Start = 1;
    tick();
    d1.Start = 0;
    check("b_ra3", d1.RA, 3);
    check("b_busy", d1.Busy, 1);
    tick();
    check("b_v3", d1.DumpValid, 1);
    check("b_idx3", d1.DumpIdx, 3);
    check("b_data3", d1.DumpData, 64'h1003);
    tick();
    check("b_drop3", d1.DumpValid, 0);
    check("b_ra4", d1.RA, 4);
    tick();
    check("b_v4", d1.DumpValid, 1);
    d1.DumpReady = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("b_hold_v4", d1.DumpValid, 1);
      check("b_hold_idx4", d1.DumpIdx, 4);
      check("b_hold_data4", d1.DumpData, 64'h1004);
    end
    d1.DumpReady = 1;
    tick();
    check("b_drop4", d1.DumpValid, 0);
    check("b_ra5", d1.RA, 5);
    tick();
    check("b_v5", d1.DumpValid, 1);
    check("b_idx5", d1.DumpIdx, 5);
    check("b_data5", d1.DumpData, 64'h1005);
    tick();
    check("b_done", d1.Done, 1);
    check("b_last_drop", d1.DumpValid, 0);
    check("b_ra_max", d1.RA, 5);
    tick();
    check("b_done_clr", d1.Done, 0);
    check("b_idle", d1.Busy, 0);
    check("b_ra_end", d1.RA, 5);

    // READ_WAIT = 3
    d2.DumpReady = 1;
    d2.Start = 1;
    tick();
    d2.Start = 0;
    for (int k = 0; k < 3; k++) begin
      check("c_wait_valid0", d2.DumpValid, 0);
      check("c_wait_ra0", d2.RA, 0);
      tick();
    end
    check("c_v0", d2.DumpValid, 1);
    check("c_idx0", d2.DumpIdx, 0);
    check("c_data0", d2.DumpData, 64'h1000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("c_wait_valid1", d2.DumpValid, 0);
      check("c_wait_ra1", d2.RA, 1);
    end
    tick();
    check("c_v1", d2.DumpValid, 1);
    check("c_idx1", d2.DumpIdx, 1);
    check("c_data1", d2.DumpData, 64'h1001);
    d2.Abort = 1;
    tick();
    d2.Abort = 0;
    check("c_abort_busy", d2.Busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
